// File: rtl/audio_pkg.sv
// Shared definitions for the audio block's PCM fetch path.
//   RATE_MAX    : sample_rate value meaning "one frame per output tick"
//   fetch_state_e: fetch sequencer states
//   frame_fmt_t : frame format latched at the tick that starts a fetch
//   nbytes()    : bytes per PCM frame for a given format (1..4)
package audio_pkg;

  localparam int RATE_MAX = 128;

  typedef enum logic [1:0] {IDLE, FETCH, DONE} fetch_state_e;

  typedef struct packed {
    logic stereo;
    logic bits16;
  } frame_fmt_t;

  function automatic logic [2:0] nbytes(input logic stereo, input logic bits16);
    case ({stereo, bits16})
      2'b00:   return 3'd1;
      2'b11:   return 3'd4;
      default: return 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/pcm_fetch_ctrl_if.sv
// FIFO read port plus sample output bus of the PCM fetch controller.
//   master : the fetch controller (pops FIFO, drives samples)
//   slave  : FIFO + downstream mixer side
interface pcm_fetch_if;
  logic [7:0]  fifo_rddata;
  logic        fifo_empty;
  logic        fifo_read;
  logic [15:0] left_sample;
  logic [15:0] right_sample;
  logic        sample_valid;
  logic        underflow;

  modport master (
    input  fifo_rddata, fifo_empty,
    output fifo_read, left_sample, right_sample, sample_valid, underflow
  );

  modport slave (
    output fifo_rddata, fifo_empty,
    input  fifo_read, left_sample, right_sample, sample_valid, underflow
  );
endinterface

// File: rtl/pcm_fetch_ctrl_rate_acc.sv
// Fractional rate accumulator. Each tick adds the clamped rate to the
// low ACC_W-1 bits of the accumulator; the top bit of the sum flags a
// frame due on that tick.
//   clk, rst : clock, synchronous active-high reset
//   rate     : requested rate, clamped to RATE_MAX
//   tick     : advance the accumulator (caller gates it to idle ticks)
//   clear    : flush, zeroes the accumulator
//   due      : combinational, high on a tick that completes a frame
module pcm_rate_acc
  import audio_pkg::*;
#(
  parameter int RATE_MAX = audio_pkg::RATE_MAX,
  parameter int ACC_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rate,
  input  logic       tick,
  input  logic       clear,
  output logic       due
);

  logic [ACC_W-1:0] acc, acc_n, r;

  always_comb begin
    r = (rate > 8'(RATE_MAX)) ? ACC_W'(RATE_MAX) : ACC_W'(rate);
    // the carry bit from the previous tick is dropped before adding
    acc_n = {1'b0, acc[ACC_W-2:0]} + r;
    due   = tick & acc_n[ACC_W-1];
  end

  always_ff @(posedge clk) begin
    if (rst || clear) acc <= '0;
    else if (tick)    acc <= acc_n;
  end

endmodule

// File: rtl/pcm_fetch_ctrl.sv
// PCM fetch sequencer. On an output-sample tick that the rate
// accumulator marks due, pops one frame (1..4 bytes) from the FWFT audio
// FIFO and assembles signed 16-bit left/right samples.
//   clk, rst     : clock, synchronous active-high reset
//   sample_rate  : playback rate, frames per tick = min(rate,128)/128
//   mode_stereo  : stereo frames
//   mode_16bit   : 16-bit little-endian samples (else 8-bit)
//   next_sample  : one-cycle tick from the I2S serializer
//   fifo_reset   : FIFO flush, aborts any fetch and zeroes state
//   bus          : FIFO read port + sample outputs (master side)
//   busy         : fetch in progress
module pcm_fetch_ctrl
  import audio_pkg::*;
#(
  parameter int RATE_MAX = audio_pkg::RATE_MAX,
  parameter int ACC_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample_rate,
  input  logic       mode_stereo,
  input  logic       mode_16bit,
  input  logic       next_sample,
  input  logic       fifo_reset,
  pcm_fetch_if.master bus,
  output logic       busy
);

  fetch_state_e      state, state_n;
  frame_fmt_t        fmt;
  logic [2:0]        nb;
  logic [1:0]        idx;
  logic              err;
  logic [3:0][7:0]   bytes_q;
  logic [3:0][7:0]   frame_b;
  logic [7:0]        cur_byte;
  logic              tick, due, last;
  logic [15:0]       asm_l, asm_r;
  logic [15:0]       left_q, right_q;

  // busy ticks are dropped without advancing the accumulator
  assign tick = next_sample & (state == IDLE);

  pcm_rate_acc #(.RATE_MAX(RATE_MAX), .ACC_W(ACC_W)) u_acc (
    .clk   (clk),
    .rst   (rst),
    .rate  (sample_rate),
    .tick  (tick),
    .clear (fifo_reset),
    .due   (due)
  );

  // missing bytes on an empty FIFO read as zero
  assign cur_byte = bus.fifo_empty ? 8'h00 : bus.fifo_rddata;
  assign last     = (state == FETCH) && ({1'b0, idx} == nb - 3'd1);

  // assemble from the bytes so far plus the one on the bus this cycle
  always_comb begin
    frame_b      = bytes_q;
    frame_b[idx] = cur_byte;
    if (fmt.bits16) begin
      asm_l = {frame_b[1], frame_b[0]};
      asm_r = fmt.stereo ? {frame_b[3], frame_b[2]} : asm_l;
    end else begin
      asm_l = {frame_b[0], 8'h00};
      asm_r = fmt.stereo ? {frame_b[1], 8'h00} : asm_l;
    end
  end

  always_comb begin
    state_n          = state;
    bus.fifo_read    = 1'b0;
    bus.sample_valid = 1'b0;
    bus.underflow    = 1'b0;
    busy             = 1'b0;
    case (state)
      IDLE:  if (due) state_n = FETCH;
      FETCH: begin
        busy          = 1'b1;
        bus.fifo_read = ~bus.fifo_empty;
        if (last) state_n = DONE;
      end
      DONE: begin
        busy             = 1'b1;
        bus.sample_valid = 1'b1;
        bus.underflow    = err;
        state_n          = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (fifo_reset) begin
      state_n          = IDLE;
      bus.fifo_read    = 1'b0;
      bus.sample_valid = 1'b0;
      bus.underflow    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      fmt     <= '0;
      nb      <= 3'd1;
      idx     <= '0;
      err     <= 1'b0;
      bytes_q <= '0;
      left_q  <= '0;
      right_q <= '0;
    end else if (fifo_reset) begin
      state   <= IDLE;
      idx     <= '0;
      err     <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (due) begin
          fmt <= '{stereo: mode_stereo, bits16: mode_16bit};
          nb  <= nbytes(mode_stereo, mode_16bit);
          idx <= '0;
          err <= 1'b0;
        end
        FETCH: begin
          bytes_q[idx] <= cur_byte;
          idx          <= idx + 2'd1;
          if (bus.fifo_empty) err <= 1'b1;
          // outputs land together with the DONE state
          if (last) begin
            left_q  <= asm_l;
            right_q <= asm_r;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.left_sample  = left_q;
  assign bus.right_sample = right_q;

endmodule
